pp_shift_accumulator: RTL and testbench

Downstream stage of the SD4 MAC partial-product generator. Each cycle it accepts one sign-magnitude partial product (5-bit `signed_pp` plus 5-bit `exp`) and aligns it into a two's-complement term by left-shifting the significand by `exp`. It accumulates terms into a saturating signed sum, and on the last term of a dot-product vector it emits the result with a term count and overflow flag. The pipeline is two stages: align, then accumulate. Valid/ready handshakes apply on both sides.

---
 rtl/pp_shift_accumulator.sv | 99 +++++++++
 tb/tb_pp_shift_accumulator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pp_shift_accumulator.sv
// Aligns sign-magnitude partial products into two's-complement terms and
// accumulates them into a saturating signed dot-product sum (align -> accumulate).
module pp_shift_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              signed_pp,
  input  logic [4:0]              exp,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic signed [ACC_W-1:0] term;
  } a_stage_t;

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  a_stage_t                a_q;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_acc;

  logic                    adv;
  logic [25:0]             mag;
  logic [ACC_W-1:0]        mag_ext;
  logic signed [ACC_W-1:0] term_in;
  logic [ACC_W:0]          sum_w;
  logic                    pos_ovf, neg_ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0]        cnt_inc;

  // Whole pipeline advances together; a held result freezes both stages.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    mag     = 26'(signed_pp[3:0]) << exp;
    mag_ext = ACC_W'(mag);
    term_in = '0;
    // Hidden bit clear means zero regardless of sign.
    if (signed_pp[3])
      term_in = signed_pp[4] ? -$signed(mag_ext) : $signed(mag_ext);
  end

  always_comb begin
    sum_w   = {acc[ACC_W-1], acc} + {a_q.term[ACC_W-1], a_q.term};
    pos_ovf = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
    neg_ovf =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
    sum_sat = $signed(sum_w[ACC_W-1:0]);
    if (pos_ovf)      sum_sat = SUM_MAX;
    else if (neg_ovf) sum_sat = SUM_MIN;
    cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      a_q.valid <= in_valid;
      a_q.last  <= in_last;
      a_q.term  <= term_in;
      out_valid <= a_q.valid & a_q.last;
      if (a_q.valid) begin
        if (a_q.last) begin
          out_sum   <= sum_sat;
          out_count <= cnt_inc;
          out_ovf   <= ovf_acc | pos_ovf | neg_ovf;
          acc       <= '0;
          cnt       <= '0;
          ovf_acc   <= 1'b0;
        end else begin
          acc     <= sum_sat;
          cnt     <= cnt_inc;
          ovf_acc <= ovf_acc | pos_ovf | neg_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_shift_accumulator.sv
// Directed bench for pp_shift_accumulator with hand-computed expected results.
module tb_pp_shift_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         signed_pp;
  logic [4:0]         exp_i;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_sum;
  logic [7:0]         out_count;
  logic               out_ovf;

  int total = 0;
  int bad   = 0;

  pp_shift_accumulator #(.ACC_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .signed_pp(signed_pp), .exp(exp_i), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] pp, input logic [4:0] e, input logic last);
    in_valid  = 1'b1;
    signed_pp = pp;
    exp_i     = e;
    in_last   = last;
    tick();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    signed_pp = '0;
    exp_i     = '0;
    in_last   = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic signed [31:0] s,
                         input logic [7:0] c, input logic o);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_count"}, out_count, c);
    chk({tag, "_ovf"}, out_ovf, o);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; signed_pp = '0; exp_i = '0; in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_out("reset", 1'b0, 0, 0, 1'b0);
    chk("reset_in_ready", in_ready, 1);
    tick(); tick();
    rst = 1'b0;

    // Mixed-sign: +8 then -(15<<2) = -52
    send(5'b01000, 5'd0, 1'b0);
    send(5'b11111, 5'd2, 1'b1);
    idle();
    chk_out("mixed", 1'b1, -52, 2, 1'b0);

    // Zero encodings with either sign
    send(5'b00000, 5'd0, 1'b0);
    chk("mixed_consumed", out_valid, 0);
    send(5'b10000, 5'd0, 1'b0);
    send(5'b10000, 5'd5, 1'b1);
    idle();
    chk_out("zero", 1'b1, 0, 3, 1'b0);

    // 35 * (15<<22) exceeds the max
    for (int i = 0; i < 35; i++) send(5'b01111, 5'd22, i == 34);
    idle();
    chk_out("sat35", 1'b1, 2147483647, 35, 1'b1);

    // 34 terms fit exactly below the max
    for (int i = 0; i < 34; i++) send(5'b01111, 5'd22, i == 33);
    idle();
    chk_out("sat34", 1'b1, 2139095040, 34, 1'b0);

    // Backpressure: vector 8+16, then 32 queued in stage A, 128 waiting at input
    send(5'b01000, 5'd0, 1'b0);
    send(5'b01000, 5'd1, 1'b1);
    out_ready = 1'b0;
    send(5'b01000, 5'd2, 1'b0);
    in_valid = 1'b1; signed_pp = 5'b01000; exp_i = 5'd4; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk_out("bp_hold", 1'b1, 24, 2, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    idle();
    chk_out("bp_next", 1'b1, 160, 2, 1'b0);

    // Back-to-back one-term vectors: 9<<1 = 18
    send(5'b01001, 5'd1, 1'b1);
    send(5'b01001, 5'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_out("b2b", 1'b1, 18, 1, 1'b0);
      send(5'b01001, 5'd1, 1'b1);
    end
    idle();
    idle();
    chk("b2b_drained", out_valid, 0);

    // Reset mid-vector
    send(5'b01000, 5'd0, 1'b0);
    send(5'b01000, 5'd0, 1'b0);
    send(5'b01000, 5'd0, 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 0, 0, 1'b0);
    chk("async_rst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    send(5'b01000, 5'd3, 1'b1);
    idle();
    chk_out("post_rst", 1'b1, 64, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
